// File: rtl/tsu_pkg.sv
// Shared definitions for the timestamp unit: record width, source tags and
// the read-sequencer state encoding.
package tsu_pkg;

    localparam int TSU_DATA_W = 128;

    localparam logic TSU_SRC_RX = 1'b0;
    localparam logic TSU_SRC_TX = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WAIT,
        HOLD
    } tsu_state_e;

    // Bit index of a one-hot two-way grant, which is also the source tag.
    function automatic logic grant_to_src(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/tsu_rr_arb2.sv
// Two-requester round-robin arbiter: a lone request wins outright, a tie goes
// to the requester that was not granted last. Purely combinational.
module tsu_rr_arb2
    import tsu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == TSU_SRC_TX) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/tsu_ts_arbiter.sv
// Shares one host timestamp read port between the RX and TX queues: one
// single-entry read at a time, record held until the host accepts it.
module tsu_ts_arbiter
    import tsu_pkg::*;
#(
    parameter int DATA_W = TSU_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              tx_en,
    input  logic              rx_q_empty,
    output logic              rx_q_rd_en,
    input  logic [DATA_W-1:0] rx_q_rd_data,
    input  logic              tx_q_empty,
    output logic              tx_q_rd_en,
    input  logic [DATA_W-1:0] tx_q_rd_data,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic [DATA_W-1:0] ts_data,
    output logic              ts_src,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  tx_cnt
);

    tsu_state_e state;
    logic       last;
    logic [1:0] req;
    logic [1:0] arb_grant;

    assign req = {tx_en && !tx_q_empty, rx_en && !rx_q_empty};

    tsu_rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .grant (arb_grant)
    );

    // ts_src doubles as the latched grant for the whole transaction; the
    // strobe is masked during reset so a reset landing in RD issues no read.
    assign rx_q_rd_en = !rst && (state == RD) && (ts_src == TSU_SRC_RX);
    assign tx_q_rd_en = !rst && (state == RD) && (ts_src == TSU_SRC_TX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= TSU_SRC_TX;
            ts_valid <= 1'b0;
            ts_data  <= '0;
            ts_src   <= TSU_SRC_RX;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb_grant) begin
                        ts_src <= grant_to_src(arb_grant);
                        state  <= RD;
                    end
                end
                RD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    ts_data  <= (ts_src == TSU_SRC_TX) ? tx_q_rd_data : rx_q_rd_data;
                    ts_valid <= 1'b1;
                    last     <= ts_src;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (ts_ready) begin
                        ts_valid <= 1'b0;
                        if (ts_src == TSU_SRC_TX) begin
                            tx_cnt <= tx_cnt + CNT_W'(1);
                        end else begin
                            rx_cnt <= rx_cnt + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tsu_ts_arbiter.md
Name: tsu_ts_arbiter

Overview:
- Shares one host-side timestamp read port between the RX and TX tsu_queue instances.
- Arbitrates round-robin between the two queues and issues single-entry reads to the selected queue.
- Holds each fetched timestamp record in an output register with a valid/ready handshake.
- Tags every record with its source and keeps a per-channel delivered-record counter for host status.

Parameters:
- DATA_W, 128, width of one queue record (timestamp plus packet info).
- CNT_W, 16, width of the per-channel delivered counters.

Ports:
- clk  in  1  block clock; both queue read ports and the host port are synchronous to it.
- rst  in  1  synchronous, active-high reset.
- rx_en  in  1  RX channel enable; 0 masks the RX queue from arbitration.
- tx_en  in  1  TX channel enable; 0 masks the TX queue from arbitration.
- rx_q_empty  in  1  RX queue empty flag.
- rx_q_rd_en  out  1  RX queue read strobe, one entry per high cycle.
- rx_q_rd_data  in  DATA_W  RX queue read data, valid the cycle after rx_q_rd_en.
- tx_q_empty  in  1  TX queue empty flag.
- tx_q_rd_en  out  1  TX queue read strobe.
- tx_q_rd_data  in  DATA_W  TX queue read data, valid the cycle after tx_q_rd_en.
- ts_valid  out  1  output record valid.
- ts_ready  in  1  host accepts the record when ts_valid && ts_ready.
- ts_data  out  DATA_W  output record.
- ts_src  out  1  source of the record: 0 = RX, 1 = TX.
- rx_cnt  out  CNT_W  RX records delivered (handshakes completed).
- tx_cnt  out  CNT_W  TX records delivered.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; all outputs 0, including ts_valid, ts_data, ts_src, both rd_en, rx_cnt and tx_cnt.
  - Last-grant pointer = TX, so RX wins the first tie.
- Request definition: rx_req = rx_en && !rx_q_empty; tx_req = tx_en && !tx_q_empty.
- State machine, registered; exactly one read outstanding at any time:
  - IDLE:
    - If exactly one request is active, grant it.
    - If both are active, grant the channel that was not granted last.
    - If a grant is made, latch it into grant/ts_src and go to RD. Otherwise stay in IDLE.
  - RD: assert the granted channel's rd_en for exactly this one cycle; go to WAIT.
  - WAIT:
    - Capture the granted channel's rd_data into ts_data at the end of this cycle.
    - Set ts_valid and go to HOLD.
    - Update the last-grant pointer to the granted channel.
  - HOLD:
    - ts_valid = 1; ts_data and ts_src stay stable.
    - On ts_ready: clear ts_valid next cycle, increment the granted channel's counter, go to IDLE.
    - Otherwise stay in HOLD indefinitely.
- rd_en is combinational from state RD and grant; never high outside RD; at most one rd_en high per cycle.
- Latency: request seen in IDLE at cycle N -> rd_en at N+1 -> data captured at end of N+2 -> ts_valid at N+3.
- Throughput: ready held high gives 4 cycles per record (IDLE, RD, WAIT, HOLD).
- Enable or empty changes after the grant (in RD, WAIT or HOLD) do not abort the transaction. The read completes and the record is delivered.
- ts_ready while ts_valid = 0 is ignored.
- Counters wrap modulo 2^CNT_W without saturation.
- Reset mid-transaction returns to IDLE immediately. A record already read from a queue is discarded, and no rd_en is issued in the reset cycle.
- Both enables low gives no reads; the block stays in IDLE regardless of the empty flags.

Decomposition:
- Package tsu_pkg:
  - TSU_SRC_RX = 1'b0, TSU_SRC_TX = 1'b1.
  - State encoding enum {IDLE, RD, WAIT, HOLD}.
  - Default DATA_W constant, shared with tsu_queue.
- Sub-module tsu_rr_arb2: 2-requester round-robin arbiter. Inputs: req[1:0], last pointer. Output: one-hot grant. Purely combinational, kept separate so it can be reused for more queues.
- All sequencing stays in tsu_ts_arbiter.

Test Plan:
- Reset, then RX non-empty only with rx_q_rd_data = 128'hA5 and ready = 1:
  - rx_q_rd_en high for exactly 1 cycle, 1 cycle after the request.
  - ts_valid 3 cycles after the request with ts_data = 128'hA5, ts_src = 0; rx_cnt = 1.
- Both queues continuously non-empty, ready = 1, for 8 records: grants alternate RX,TX,RX,TX...; rx_cnt = tx_cnt = 4; one record per 4 cycles.
- ts_ready low for 20 cycles after ts_valid:
  - ts_data and ts_src stable and no rd_en during the stall.
  - One handshake after ready rises; the counter increments once.
- rx_en = 0 with both queues non-empty: only TX is read; rx_q_rd_en never asserted; rx_cnt stays 0.
- rst asserted in the WAIT state: next cycle state = IDLE, ts_valid = 0, both counters 0, no record delivered.
- tx_cnt preloaded by 65535 handshakes, then one more TX record: tx_cnt wraps to 0.
